// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the Galois LFSR generator/checker.
//   lfsr_mode_e   : operating mode encoding (GEN = 0, CHK = 1)
//   default_poly  : maximal-length right-shift Galois tap mask for widths 3..32
// -----------------------------------------------------------------------------
package lfsr_pkg;

    typedef enum logic {
        GEN = 1'b0,
        CHK = 1'b1
    } lfsr_mode_e;

    // Masks are for the right-shift form: s' = (s >> 1) ^ (s[0] ? mask : 0).
    // Widths outside 3..32 return zero, which makes an obviously dead LFSR.
    function automatic logic [31:0] default_poly(input int unsigned width);
        logic [31:0] mask;
        case (width)
            3:       mask = 32'h0000_0006;
            4:       mask = 32'h0000_000C;
            5:       mask = 32'h0000_0014;
            6:       mask = 32'h0000_0030;
            7:       mask = 32'h0000_0060;
            8:       mask = 32'h0000_00B8;
            9:       mask = 32'h0000_0110;
            10:      mask = 32'h0000_0240;
            11:      mask = 32'h0000_0500;
            12:      mask = 32'h0000_0829;
            13:      mask = 32'h0000_100D;
            14:      mask = 32'h0000_2015;
            15:      mask = 32'h0000_6000;
            16:      mask = 32'h0000_D008;
            17:      mask = 32'h0001_2000;
            18:      mask = 32'h0002_0400;
            19:      mask = 32'h0004_0023;
            20:      mask = 32'h0009_0000;
            21:      mask = 32'h0014_0000;
            22:      mask = 32'h0030_0000;
            23:      mask = 32'h0042_0000;
            24:      mask = 32'h00E1_0000;
            25:      mask = 32'h0120_0000;
            26:      mask = 32'h0200_0023;
            27:      mask = 32'h0400_0013;
            28:      mask = 32'h0900_0000;
            29:      mask = 32'h1400_0000;
            30:      mask = 32'h2000_0029;
            31:      mask = 32'h4800_0000;
            32:      mask = 32'h8020_0003;
            default: mask = 32'h0000_0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/galois_lfsr_step.sv
// -----------------------------------------------------------------------------
// galois_lfsr_step
// Purely combinational single step of a right-shift Galois LFSR.
//   state_i : current LFSR word
//   next_o  : (state_i >> 1) ^ (state_i[0] ? POLY : 0)
// -----------------------------------------------------------------------------
module galois_lfsr_step
    import lfsr_pkg::*;
#(
    parameter int unsigned           BIT_WIDTH = 8,
    parameter logic [BIT_WIDTH-1:0]  POLY      = BIT_WIDTH'(default_poly(BIT_WIDTH))
) (
    input  logic [BIT_WIDTH-1:0] state_i,
    output logic [BIT_WIDTH-1:0] next_o
);

    assign next_o = (state_i >> 1) ^ (state_i[0] ? POLY : '0);

endmodule

// File: rtl/galois_lfsr_gen_chk.sv
// -----------------------------------------------------------------------------
// galois_lfsr_gen_chk
// Galois LFSR PRBS generator (mode 0) / self-synchronising checker (mode 1).
//   clk, rst         : clock, synchronous active-high reset
//   mode             : 0 = generate, 1 = check
//   enable           : generator advance request
//   load_evt         : load seed_data (zero maps to all ones), clear err_cnt
//   seed_data        : seed value
//   chk_vld/chk_data : checker input word
//   lfsr_vld         : output word valid (1-cycle latency)
//   lfsr_data        : generated word / expected word
//   lfsr_done        : last word of the period (generator)
//   locked           : checker locked
//   err_flag         : one pulse per mismatched word while locked
//   err_cnt          : saturating mismatch count
// -----------------------------------------------------------------------------
module galois_lfsr_gen_chk
    import lfsr_pkg::*;
#(
    parameter int unsigned           BIT_WIDTH     = 8,
    parameter logic [BIT_WIDTH-1:0]  POLY          = BIT_WIDTH'(default_poly(BIT_WIDTH)),
    parameter int unsigned           LOCK_CNT      = 4,
    parameter int unsigned           ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic                     enable,
    input  logic                     load_evt,
    input  logic [BIT_WIDTH-1:0]     seed_data,
    input  logic                     chk_vld,
    input  logic [BIT_WIDTH-1:0]     chk_data,
    output logic                     lfsr_vld,
    output logic [BIT_WIDTH-1:0]     lfsr_data,
    output logic                     lfsr_done,
    output logic                     locked,
    output logic                     err_flag,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

    localparam int unsigned          STREAK_W = $clog2(LOCK_CNT + 1);
    localparam logic [STREAK_W-1:0]  LOCK_TC  = STREAK_W'(LOCK_CNT);

    logic [BIT_WIDTH-1:0]     state_q, state_d;
    logic [BIT_WIDTH-1:0]     seed_q, seed_d;
    lfsr_mode_e               mode_q, mode_d;
    logic                     vld_q, vld_d;
    logic [BIT_WIDTH-1:0]     data_q, data_d;
    logic                     done_q, done_d;
    logic                     locked_q, locked_d;
    logic                     flag_q, flag_d;
    logic [ERR_CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [STREAK_W-1:0]      match_q, match_d;
    logic [STREAK_W-1:0]      miss_q, miss_d;

    logic [BIT_WIDTH-1:0]     step_state;
    logic [BIT_WIDTH-1:0]     step_chk;
    logic [BIT_WIDTH-1:0]     seed_fix;
    logic [STREAK_W-1:0]      match_inc;
    logic [STREAK_W-1:0]      miss_inc;
    logic                     word_match;

    galois_lfsr_step #(.BIT_WIDTH(BIT_WIDTH), .POLY(POLY)) u_step_state (
        .state_i (state_q),
        .next_o  (step_state)
    );

    // Unlocked checker reseeds from the incoming word so it can follow any
    // phase of the sequence.
    galois_lfsr_step #(.BIT_WIDTH(BIT_WIDTH), .POLY(POLY)) u_step_chk (
        .state_i (chk_data),
        .next_o  (step_chk)
    );

    // An all-zero state would lock the LFSR up forever.
    assign seed_fix   = (seed_data == '0) ? '1 : seed_data;
    assign match_inc  = match_q + 1'b1;
    assign miss_inc   = miss_q + 1'b1;
    assign word_match = (chk_data == state_q);

    always_comb begin
        state_d  = state_q;
        seed_d   = seed_q;
        mode_d   = lfsr_mode_e'(mode);
        vld_d    = 1'b0;
        data_d   = data_q;
        done_d   = 1'b0;
        locked_d = locked_q;
        flag_d   = 1'b0;
        cnt_d    = cnt_q;
        match_d  = match_q;
        miss_d   = miss_q;

        if (load_evt) begin
            state_d  = seed_fix;
            seed_d   = seed_fix;
            cnt_d    = '0;
            match_d  = '0;
            miss_d   = '0;
            locked_d = 1'b0;
        end else if (mode_d != mode_q) begin
            // Mode switch cycle: no word, lock history is meaningless now.
            locked_d = 1'b0;
            match_d  = '0;
            miss_d   = '0;
        end else if (mode_q == GEN) begin
            if (enable) begin
                vld_d   = 1'b1;
                data_d  = state_q;
                state_d = step_state;
                // Next state returning to the seed marks the period end.
                done_d  = (step_state == seed_q);
            end
        end else if (chk_vld) begin
            vld_d  = 1'b1;
            data_d = state_q;
            if (!locked_q) begin
                state_d = step_chk;
                if (word_match) begin
                    if (match_inc == LOCK_TC) begin
                        locked_d = 1'b1;
                        match_d  = '0;
                        miss_d   = '0;
                    end else begin
                        match_d = match_inc;
                    end
                end else begin
                    match_d = '0;
                end
            end else begin
                state_d = step_state;
                if (word_match) begin
                    miss_d = '0;
                end else begin
                    flag_d = 1'b1;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (miss_inc == LOCK_TC) begin
                        locked_d = 1'b0;
                        match_d  = '0;
                        miss_d   = '0;
                    end else begin
                        miss_d = miss_inc;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= '1;
            seed_q   <= '1;
            mode_q   <= GEN;
            vld_q    <= 1'b0;
            data_q   <= '0;
            done_q   <= 1'b0;
            locked_q <= 1'b0;
            flag_q   <= 1'b0;
            cnt_q    <= '0;
            match_q  <= '0;
            miss_q   <= '0;
        end else begin
            state_q  <= state_d;
            seed_q   <= seed_d;
            mode_q   <= mode_d;
            vld_q    <= vld_d;
            data_q   <= data_d;
            done_q   <= done_d;
            locked_q <= locked_d;
            flag_q   <= flag_d;
            cnt_q    <= cnt_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
        end
    end

    assign lfsr_vld  = vld_q;
    assign lfsr_data = data_q;
    assign lfsr_done = done_q;
    assign locked    = locked_q;
    assign err_flag  = flag_q;
    assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_galois_lfsr_gen_chk.sv
// -----------------------------------------------------------------------------
// tb_galois_lfsr_gen_chk
// Directed bench for galois_lfsr_gen_chk (8-bit, POLY B8, LOCK_CNT 4, 2-bit
// error counter so saturation is reachable quickly).
// -----------------------------------------------------------------------------
module tb_galois_lfsr_gen_chk;

    logic       clk = 1'b0;
    logic       rst, mode, enable, load_evt, chk_vld;
    logic [7:0] seed_data, chk_data;
    logic       lfsr_vld, lfsr_done, locked, err_flag;
    logic [7:0] lfsr_data;
    logic [1:0] err_cnt;

    always #5 clk = ~clk;

    galois_lfsr_gen_chk #(
        .BIT_WIDTH     (8),
        .POLY          (8'hB8),
        .LOCK_CNT      (4),
        .ERR_CNT_WIDTH (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .enable    (enable),
        .load_evt  (load_evt),
        .seed_data (seed_data),
        .chk_vld   (chk_vld),
        .chk_data  (chk_data),
        .lfsr_vld  (lfsr_vld),
        .lfsr_data (lfsr_data),
        .lfsr_done (lfsr_done),
        .locked    (locked),
        .err_flag  (err_flag),
        .err_cnt   (err_cnt)
    );

    typedef struct {
        logic       vld;
        logic [7:0] data;
        logic       done;
        logic       lk;
        logic       fl;
        logic [1:0] cnt;
    } exp_t;

    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    string phase  = "init";
    bit    seen[256];

    function automatic logic [7:0] tb_step(input logic [7:0] s);
        return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
    endfunction

    function automatic exp_t mk(input logic v, input logic [7:0] d, input logic dn,
                                input logic lk, input logic fl, input logic [1:0] c);
        exp_t e;
        e.vld = v; e.data = d; e.done = dn; e.lk = lk; e.fl = fl; e.cnt = c;
        return e;
    endfunction

    task automatic chk_field(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expected outputs, then compare
    // what the DUT registered on that edge.
    task automatic cyc(input logic r, input logic md, input logic en, input logic ld,
                       input logic cv, input logic [7:0] sd, input logic [7:0] cd,
                       input exp_t e);
        exp_t x;
        rst = r; mode = md; enable = en; load_evt = ld;
        chk_vld = cv; seed_data = sd; chk_data = cd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk_field("vld", 32'(lfsr_vld), 32'(x.vld));
        if (x.vld) chk_field("data", 32'(lfsr_data), 32'(x.data));
        chk_field("done",   32'(lfsr_done), 32'(x.done));
        chk_field("locked", 32'(locked),    32'(x.lk));
        chk_field("errflg", 32'(err_flag),  32'(x.fl));
        chk_field("errcnt", 32'(err_cnt),   32'(x.cnt));
    endtask

    initial begin
        logic [7:0] w;
        logic [7:0] seed_m;
        int         gi;
        logic [6:0] pat;

        // ---------------- reset ----------------
        phase = "reset";
        cyc(1, 0, 0, 0, 0, 8'h00, 8'h00, mk(0, 8'h00, 0, 0, 0, 2'd0));
        cyc(1, 0, 1, 0, 1, 8'h00, 8'h00, mk(0, 8'h00, 0, 0, 0, 2'd0));
        chk_field("rst_data", 32'(lfsr_data), 32'h0);

        // ---------------- generator without a load ----------------
        phase = "noload";
        cyc(0, 0, 1, 0, 0, 8'h00, 8'h00, mk(1, 8'hFF, 0, 0, 0, 2'd0));
        cyc(0, 0, 1, 0, 0, 8'h00, 8'h00, mk(1, 8'hC7, 0, 0, 0, 2'd0));

        // ---------------- full period from seed 01 ----------------
        phase = "period";
        cyc(0, 0, 1, 1, 0, 8'h01, 8'h00, mk(0, 8'h00, 0, 0, 0, 2'd0));
        w = 8'h01;
        for (int i = 0; i < 300; i++) begin
            cyc(0, 0, 1, 0, 0, 8'h00, 8'h00, mk(1, w, (i % 255) == 254, 0, 0, 2'd0));
            if (i < 255) begin
                checks++;
                assert (!seen[int'(lfsr_data)]) else begin
                    errors++;
                    $error("FAIL %s/distinct observed=%0h expected=new_word", phase, lfsr_data);
                end
                seen[int'(lfsr_data)] = 1'b1;
            end
            w = tb_step(w);
        end

        // ---------------- enable toggling: no skip, no repeat ----------------
        phase = "toggle";
        gi  = 300;
        pat = 7'b1101001;
        for (int i = 0; i < 7; i++) begin
            if (pat[i]) begin
                cyc(0, 0, 1, 0, 0, 8'h00, 8'h00, mk(1, w, (gi % 255) == 254, 0, 0, 2'd0));
                w = tb_step(w);
                gi++;
            end else begin
                cyc(0, 0, 0, 0, 0, 8'h00, 8'h00, mk(0, w, 0, 0, 0, 2'd0));
            end
        end

        // ---------------- zero seed maps to all ones ----------------
        phase  = "zeroseed";
        seed_m = 8'hFF;
        cyc(0, 0, 1, 1, 0, 8'h00, 8'h00, mk(0, 8'h00, 0, 0, 0, 2'd0));
        w = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            cyc(0, 0, 1, 0, 0, 8'h00, 8'h00, mk(1, w, tb_step(w) == seed_m, 0, 0, 2'd0));
            w = tb_step(w);
        end

        // ---------------- load beats enable ----------------
        phase  = "priority";
        seed_m = 8'h3C;
        cyc(0, 0, 1, 1, 0, 8'h3C, 8'h00, mk(0, 8'h00, 0, 0, 0, 2'd0));
        cyc(0, 0, 1, 0, 0, 8'h00, 8'h00, mk(1, 8'h3C, tb_step(8'h3C) == seed_m, 0, 0, 2'd0));

        // ---------------- checker: switch mode, load, lock ----------------
        phase = "modechg";
        cyc(0, 1, 1, 0, 1, 8'h00, 8'h00, mk(0, 8'h00, 0, 0, 0, 2'd0));
        phase = "chkload";
        cyc(0, 1, 0, 1, 1, 8'h5C, 8'h99, mk(0, 8'h00, 0, 0, 0, 2'd0));
        phase = "lock";
        w = 8'h5C;
        for (int k = 0; k < 6; k++) begin
            cyc(0, 1, 0, 0, 1, 8'h00, w, mk(1, w, 0, k >= 3, 0, 2'd0));
            w = tb_step(w);
        end

        phase = "biterr";
        cyc(0, 1, 0, 0, 1, 8'h00, w ^ 8'h01, mk(1, w, 0, 1, 1, 2'd1));
        w = tb_step(w);
        phase = "gap";
        cyc(0, 1, 1, 0, 0, 8'h00, 8'h00, mk(0, w, 0, 1, 0, 2'd1));
        phase = "resume";
        cyc(0, 1, 0, 0, 1, 8'h00, w, mk(1, w, 0, 1, 0, 2'd1));
        w = tb_step(w);

        // Four bad words: counter saturates at 3, lock drops on the fourth.
        phase = "unlock";
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1, 0, 0, 1, 8'h00, w ^ 8'h5A,
                mk(1, w, 0, k < 3, 1, (k >= 1) ? 2'd3 : 2'd2));
            w = tb_step(w);
        end

        phase = "relock";
        for (int k = 0; k < 6; k++) begin
            cyc(0, 1, 0, 0, 1, 8'h00, w, mk(1, w, 0, k >= 3, 0, 2'd3));
            w = tb_step(w);
        end

        phase = "loadclr";
        cyc(0, 1, 0, 1, 1, 8'h5C, w, mk(0, 8'h00, 0, 0, 0, 2'd0));
        w = 8'h5C;
        for (int k = 0; k < 2; k++) begin
            cyc(0, 1, 0, 0, 1, 8'h00, w, mk(1, w, 0, 0, 0, 2'd0));
            w = tb_step(w);
        end

        // ---------------- reset mid-stream ----------------
        phase = "midrst";
        cyc(1, 0, 1, 0, 1, 8'h00, w, mk(0, 8'h00, 0, 0, 0, 2'd0));
        chk_field("rst_data", 32'(lfsr_data), 32'h0);
        phase = "postrst";
        cyc(0, 0, 1, 0, 0, 8'h00, 8'h00, mk(1, 8'hFF, 0, 0, 0, 2'd0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
